// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the two-requester APB arbiter: FSM state encoding,
// the 6-bit address region codes and the one-hot slave select constants.
package apb_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    // addr[31:26] region codes
    localparam logic [5:0] REGION_S0 = 6'b100000;
    localparam logic [5:0] REGION_S1 = 6'b100001;
    localparam logic [5:0] REGION_S2 = 6'b100010;

    // One-hot Pselx values
    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

    // Timeout counter width, enough for TIMEOUT up to 255
    localparam int unsigned TCNT_W = 8;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB bus between the arbiter (master) and the slaves (slave).
interface apb_req_arbiter_if;

    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic        Penable;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Paddr, Pwdata, Pwrite, Pselx, Penable,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Paddr, Pwdata, Pwrite, Pselx, Penable,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational region decoder: addr[31:26] -> one-hot Pselx plus an
// unmapped flag for any code outside the three slave regions.
module apb_addr_decode
    import apb_req_arbiter_pkg::*;
(
    input  logic [5:0] region,
    output logic [2:0] sel,
    output logic       unmapped
);

    // Map the region code onto a slave select
    always_comb begin
        sel      = PSEL_NONE;
        unmapped = 1'b0;
        case (region)
            REGION_S0: sel = PSEL_S0;
            REGION_S1: sel = PSEL_S1;
            REGION_S2: sel = PSEL_S2;
            default:   unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port with
// a three-slave decode, wait-state timeout and one-cycle done pulses.
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req0_write,
    input  logic [31:0]        req0_addr,
    input  logic [31:0]        req0_wdata,
    input  logic               req1_valid,
    input  logic               req1_write,
    input  logic [31:0]        req1_addr,
    input  logic [31:0]        req1_wdata,
    output logic               req0_done,
    output logic               req1_done,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    apb_req_arbiter_if.master  apb
);

    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_d;
    logic              last_grant;
    logic              owner;
    logic [TCNT_W-1:0] tcnt;

    logic              win;
    logic              win_write;
    logic [31:0]       win_addr;
    logic [31:0]       win_wdata;
    logic [2:0]        dec_sel;
    logic              dec_unmapped;

    logic              grant;
    logic              finish_ok;
    logic              finish_abort;
    logic              done_now;

    assign done_now = req0_done | req1_done;

    // Round-robin winner selection and payload mux
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else if (req1_valid) begin
            win = 1'b1;
        end
        win_write = win ? req1_write : req0_write;
        win_addr  = win ? req1_addr  : req0_addr;
        win_wdata = win ? req1_wdata : req0_wdata;
    end

    apb_addr_decode u_decode (
        .region   (win_addr[31:26]),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    // Next-state logic; no grant while a done pulse is on the outputs
    always_comb begin
        state_d      = state;
        grant        = 1'b0;
        finish_ok    = 1'b0;
        finish_abort = 1'b0;
        case (state)
            IDLE: begin
                if ((req0_valid || req1_valid) && !done_now) begin
                    grant = 1'b1;
                    if (!dec_unmapped) begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.Pready) begin
                    finish_ok = 1'b1;
                    state_d   = IDLE;
                end else if (tcnt == TIMEOUT_LAST) begin
                    finish_abort = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Wait-state counter, cleared whenever the FSM is not stalled in ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (state != ACCESS || finish_ok || finish_abort) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end

    // Registered APB outputs, arbitration history and responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apb.Paddr   <= '0;
            apb.Pwdata  <= '0;
            apb.Pwrite  <= 1'b0;
            apb.Pselx   <= PSEL_NONE;
            apb.Penable <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;

            if (grant) begin
                apb.Paddr  <= win_addr;
                apb.Pwdata <= win_wdata;
                apb.Pwrite <= win_write;
                last_grant <= win;
                owner      <= win;
                if (dec_unmapped) begin
                    req0_done <= ~win;
                    req1_done <= win;
                    rsp_err   <= 1'b1;
                end else begin
                    apb.Pselx <= dec_sel;
                end
            end

            if (state == SETUP) begin
                apb.Penable <= 1'b1;
            end

            if (finish_ok || finish_abort) begin
                apb.Pselx   <= PSEL_NONE;
                apb.Penable <= 1'b0;
                req0_done   <= ~owner;
                req1_done   <= owner;
                rsp_err     <= finish_abort ? 1'b1 : apb.Pslverr;
                rsp_rdata   <= (finish_ok && !apb.Pwrite) ? apb.Prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: scenario tasks with randomized
// payloads and slave timing, checked against a transaction-level model.
module tb_apb_req_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_done, req1_done, rsp_err;
    logic [31:0] rsp_rdata;

    apb_req_arbiter_if apb_bus ();

    apb_req_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req0_done  (req0_done),
        .req1_done  (req1_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb        (apb_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = 1;

    // Slave behaviour for the current transfer
    int          slv_wait;
    logic [31:0] slv_rdata;
    logic        slv_err;
    // Payload the APB bus must carry during ACCESS
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_write;

    // Observations of the last transfer
    int          o_lat, o_who, o_acc;
    logic [31:0] o_rdata;
    logic        o_err, o_setup_en;
    logic [2:0]  o_sel, o_setup_sel;
    bit          o_payload_ok, o_both;

    // Model: slave select implied by the address region
    function automatic logic [2:0] model_sel(input logic [31:0] a);
        int r;
        r = int'(a >> 26);
        if (r >= 32 && r <= 34) return 3'(1 << (r - 32));
        return 3'b000;
    endfunction

    // Model: round-robin, the requester not granted last wins a tie
    function automatic int model_winner(input bit v0, input bit v1);
        if (v0 && v1) return 1 - model_last;
        return v1 ? 1 : 0;
    endfunction

    task automatic set_req(input int n, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (n == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic set_exp(input logic [31:0] a, input logic [31:0] d, input bit w);
        exp_addr = a; exp_wdata = d; exp_write = w;
    endtask

    // Slave responder: ready after slv_wait ACCESS cycles, noise otherwise
    task automatic drive_slave();
        if (apb_bus.Penable && apb_bus.Pselx != 3'b000 && o_acc > slv_wait) begin
            apb_bus.Pready  = 1'b1;
            apb_bus.Prdata  = slv_rdata;
            apb_bus.Pslverr = slv_err;
        end else begin
            apb_bus.Pready  = (apb_bus.Penable && apb_bus.Pselx != 3'b000) ? 1'b0 : 1'($urandom);
            apb_bus.Prdata  = $urandom;
            apb_bus.Pslverr = 1'($urandom);
        end
    endtask

    // Monitor one transfer until a done pulse or the cycle bound expires
    task automatic observe(input int bound);
        bit seen;
        o_lat = 0; o_who = -1; o_acc = 0; o_rdata = '0; o_err = 1'b0;
        o_sel = '0; o_setup_sel = '0; o_setup_en = 1'b0;
        o_payload_ok = 1; o_both = 0; seen = 0;
        drive_slave();
        for (int c = 1; c <= bound && !seen; c++) begin
            @(negedge clk);
            if (req0_done && req1_done) o_both = 1;
            o_sel |= apb_bus.Pselx;
            if (c == 1) begin
                o_setup_sel = apb_bus.Pselx;
                o_setup_en  = apb_bus.Penable;
            end
            if (apb_bus.Penable) begin
                o_acc++;
                if (apb_bus.Paddr !== exp_addr || apb_bus.Pwdata !== exp_wdata || apb_bus.Pwrite !== exp_write)
                    o_payload_ok = 0;
            end
            if (req0_done || req1_done) begin
                seen = 1; o_lat = c; o_who = req1_done ? 1 : 0;
                o_rdata = rsp_rdata; o_err = rsp_err;
            end else begin
                drive_slave();
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({apb_bus.Paddr, apb_bus.Pwdata, apb_bus.Pwrite, apb_bus.Pselx, apb_bus.Penable} !== 69'd0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", {apb_bus.Paddr, apb_bus.Pwdata, apb_bus.Pwrite, apb_bus.Pselx, apb_bus.Penable}); end
        n_checks++; if ({req0_done, req1_done, rsp_rdata, rsp_err} !== 35'd0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {req0_done, req1_done, rsp_rdata, rsp_err}); end
        rst = 1'b1;
        model_last = 1;
        @(negedge clk);
        n_checks++; if ({apb_bus.Pselx, apb_bus.Penable, req0_done, req1_done} !== 6'd0) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 0", {apb_bus.Pselx, apb_bus.Penable, req0_done, req1_done}); end
    endtask

    task automatic test_single_write();
        int w;
        set_req(0, 1, 1, 32'h8000_0010, 32'hDEAD_BEEF);
        set_exp(32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
        slv_wait = 0; slv_rdata = $urandom; slv_err = 1'b0;
        w = model_winner(1, 0);
        observe(40);
        model_last = w;
        n_checks++; if (o_setup_sel !== 3'b001 || o_setup_en !== 1'b0) begin n_fail++; $display("FAIL wr_setup: got sel=%b en=%b expected sel=001 en=0", o_setup_sel, o_setup_en); end
        n_checks++; if (o_lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", o_lat); end
        n_checks++; if (o_who !== w) begin n_fail++; $display("FAIL wr_who: got %0d expected %0d", o_who, w); end
        n_checks++; if (o_err !== 1'b0 || o_rdata !== 32'd0) begin n_fail++; $display("FAIL wr_rsp: got err=%b rdata=%h expected err=0 rdata=0", o_err, o_rdata); end
        n_checks++; if (o_acc !== 1 || !o_payload_ok) begin n_fail++; $display("FAIL wr_access: got acc=%0d payload_ok=%0d expected acc=1 payload_ok=1", o_acc, o_payload_ok); end
        set_req(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++; if ({req0_done, req1_done, apb_bus.Pselx, apb_bus.Penable} !== 6'd0) begin n_fail++; $display("FAIL wr_after_done: got %b expected 0", {req0_done, req1_done, apb_bus.Pselx, apb_bus.Penable}); end
    endtask

    task automatic test_read_wait();
        int w;
        set_req(1, 1, 0, 32'h8400_0004, $urandom);
        set_exp(32'h8400_0004, req1_wdata, 1'b0);
        slv_wait = 3; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
        w = model_winner(0, 1);
        observe(40);
        model_last = w;
        n_checks++; if (o_who !== w || o_lat !== 6) begin n_fail++; $display("FAIL rd_timing: got who=%0d lat=%0d expected who=%0d lat=6", o_who, o_lat, w); end
        n_checks++; if (o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got rdata=%h err=%b expected rdata=12345678 err=0", o_rdata, o_err); end
        n_checks++; if (o_setup_sel !== 3'b010 || o_acc !== 4 || !o_payload_ok) begin n_fail++; $display("FAIL rd_access: got sel=%b acc=%0d stable=%0d expected sel=010 acc=4 stable=1", o_setup_sel, o_acc, o_payload_ok); end
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [31:0] a [2];
        logic [31:0] d [2];
        bit          wr[2];
        int          w, prev_done;
        for (int r = 0; r < 2; r++) begin
            a[r] = (32'(32 + $urandom_range(0, 2)) << 26) | ($urandom & 32'h03FF_FFFC);
            d[r] = $urandom; wr[r] = 1'($urandom);
            set_req(r, 1, wr[r], a[r], d[r]);
        end
        prev_done = 0;
        for (int i = 0; i < 4; i++) begin
            w = model_winner(1, 1);
            set_exp(a[w], d[w], wr[w]);
            slv_wait = $urandom_range(0, 2); slv_rdata = $urandom; slv_err = 1'b0;
            observe(40);
            n_checks++; if (o_who !== w) begin n_fail++; $display("FAIL cont_who[%0d]: got %0d expected %0d", i, o_who, w); end
            n_checks++; if (o_both || o_rdata !== (wr[w] ? 32'd0 : slv_rdata) || !o_payload_ok) begin n_fail++; $display("FAIL cont_rsp[%0d]: got both=%0d rdata=%h ok=%0d expected both=0 rdata=%h ok=1", i, o_both, o_rdata, o_payload_ok, wr[w] ? 32'd0 : slv_rdata); end
            if (i > 0) begin
                n_checks++; if (cyc - prev_done < 4) begin n_fail++; $display("FAIL cont_gap[%0d]: got %0d expected >=4", i, cyc - prev_done); end
            end
            prev_done = cyc;
            model_last = w;
            a[w] = (32'(32 + $urandom_range(0, 2)) << 26) | ($urandom & 32'h03FF_FFFC);
            d[w] = $urandom; wr[w] = 1'($urandom);
            set_req(w, 1, wr[w], a[w], d[w]);
        end
        set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int w;
        set_req(0, 1, 0, 32'h8800_0000, $urandom);
        set_exp(32'h8800_0000, req0_wdata, 1'b0);
        slv_wait = 1000; slv_rdata = $urandom; slv_err = 1'b0;
        w = model_winner(1, 0);
        observe(60);
        model_last = w;
        n_checks++; if (o_lat !== 2 + TO || o_acc !== TO) begin n_fail++; $display("FAIL to_timing: got lat=%0d acc=%0d expected lat=%0d acc=%0d", o_lat, o_acc, 2 + TO, TO); end
        n_checks++; if (o_who !== w || o_err !== 1'b1 || o_rdata !== 32'd0) begin n_fail++; $display("FAIL to_rsp: got who=%0d err=%b rdata=%h expected who=%0d err=1 rdata=0", o_who, o_err, o_rdata, w); end
        n_checks++; if (apb_bus.Pselx !== 3'b000 || apb_bus.Penable !== 1'b0 || o_setup_sel !== 3'b100) begin n_fail++; $display("FAIL to_bus: got sel=%b en=%b setup_sel=%b expected 000 0 100", apb_bus.Pselx, apb_bus.Penable, o_setup_sel); end
        set_req(0, 0, 0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_unmapped();
        int w;
        set_req(1, 1, 1, 32'h0000_1000, $urandom);
        set_exp(32'h0000_1000, req1_wdata, 1'b1);
        slv_wait = 0; slv_rdata = $urandom; slv_err = 1'b0;
        w = model_winner(0, 1);
        observe(40);
        model_last = w;
        n_checks++; if (o_lat !== 1 || o_who !== w) begin n_fail++; $display("FAIL um_timing: got lat=%0d who=%0d expected lat=1 who=%0d", o_lat, o_who, w); end
        n_checks++; if (o_sel !== 3'b000 || o_acc !== 0) begin n_fail++; $display("FAIL um_bus: got sel=%b acc=%0d expected sel=000 acc=0", o_sel, o_acc); end
        n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin n_fail++; $display("FAIL um_rsp: got err=%b rdata=%h expected err=1 rdata=0", o_err, o_rdata); end
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a [2];
        logic [31:0] d [2];
        bit          wr[2];
        bit          v0, v1, mapped, tmo;
        int          w, k, e_lat, e_acc;
        logic [31:0] e_rdata;
        logic        e_err;
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(1, 3);
            v0 = k[0]; v1 = k[1];
            for (int r = 0; r < 2; r++) begin
                k = $urandom_range(0, 3);
                a[r] = (32'(k < 3 ? 32 + k : $urandom_range(0, 31)) << 26) | ($urandom & 32'h03FF_FFFF);
                d[r] = $urandom; wr[r] = 1'($urandom);
            end
            set_req(0, v0, wr[0], a[0], d[0]);
            set_req(1, v1, wr[1], a[1], d[1]);
            w = model_winner(v0, v1);
            set_exp(a[w], d[w], wr[w]);
            slv_wait = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            slv_rdata = $urandom; slv_err = 1'($urandom);
            mapped = (model_sel(a[w]) != 3'b000);
            tmo    = mapped && slv_wait >= TO;
            e_lat  = !mapped ? 1 : (tmo ? 2 + TO : 3 + slv_wait);
            e_acc  = !mapped ? 0 : (tmo ? TO : slv_wait + 1);
            e_err  = !mapped || tmo || slv_err;
            e_rdata = (mapped && !tmo && !wr[w]) ? slv_rdata : 32'd0;
            observe(60);
            model_last = w;
            n_checks++; if (o_who !== w || o_lat !== e_lat || o_both) begin n_fail++; $display("FAIL rnd_timing[%0d]: got who=%0d lat=%0d both=%0d expected who=%0d lat=%0d both=0", i, o_who, o_lat, o_both, w, e_lat); end
            n_checks++; if (o_err !== e_err || o_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got err=%b rdata=%h expected err=%b rdata=%h", i, o_err, o_rdata, e_err, e_rdata); end
            n_checks++; if (o_sel !== model_sel(a[w]) || o_acc !== e_acc || !o_payload_ok) begin n_fail++; $display("FAIL rnd_bus[%0d]: got sel=%b acc=%0d ok=%0d expected sel=%b acc=%0d ok=1", i, o_sel, o_acc, o_payload_ok, model_sel(a[w]), e_acc); end
            set_req(0, 0, 0, '0, '0); set_req(1, 0, 0, '0, '0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        bit got_done;
        // req0 alone first so requester 1 is next in line
        set_req(0, 1, 1, 32'h8000_0100, $urandom);
        set_exp(32'h8000_0100, req0_wdata, 1'b1);
        slv_wait = 0; slv_rdata = $urandom; slv_err = 1'b0;
        w = model_winner(1, 0);
        observe(40);
        model_last = w;
        n_checks++; if (o_who !== 0) begin n_fail++; $display("FAIL rm_first: got %0d expected 0", o_who); end
        set_req(0, 0, 0, '0, '0);
        @(negedge clk);
        // both pending; requester 1 wins and is stalled in ACCESS
        set_req(0, 1, 0, 32'h8400_0040, $urandom);
        set_req(1, 1, 1, 32'h8800_0080, $urandom);
        apb_bus.Pready = 1'b0;
        for (int i = 0; i < 10 && !apb_bus.Penable; i++) @(negedge clk);
        n_checks++; if (apb_bus.Penable !== 1'b1 || apb_bus.Pselx !== model_sel(req1_addr)) begin n_fail++; $display("FAIL rm_access: got en=%b sel=%b expected en=1 sel=%b", apb_bus.Penable, apb_bus.Pselx, model_sel(req1_addr)); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({apb_bus.Paddr, apb_bus.Pwdata, apb_bus.Pwrite, apb_bus.Pselx, apb_bus.Penable, req0_done, req1_done, rsp_rdata, rsp_err} !== 104'd0) begin n_fail++; $display("FAIL rm_async_clear: got %h expected 0", {apb_bus.Paddr, apb_bus.Pwdata, apb_bus.Pwrite, apb_bus.Pselx, apb_bus.Penable, req0_done, req1_done, rsp_rdata, rsp_err}); end
        got_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (req0_done || req1_done || apb_bus.Pselx != 3'b000) got_done = 1;
        end
        n_checks++; if (got_done) begin n_fail++; $display("FAIL rm_quiet_in_reset: got activity=1 expected 0"); end
        rst = 1'b1;
        model_last = 1;
        w = model_winner(1, 1);
        set_exp(req0_addr, req0_wdata, req0_write);
        slv_wait = 0; slv_rdata = $urandom; slv_err = 1'b0;
        observe(40);
        model_last = w;
        n_checks++; if (o_who !== w || o_lat !== 3) begin n_fail++; $display("FAIL rm_regrant0: got who=%0d lat=%0d expected who=%0d lat=3", o_who, o_lat, w); end
        set_req(0, 0, 0, '0, '0);
        w = model_winner(0, 1);
        set_exp(req1_addr, req1_wdata, req1_write);
        slv_wait = 0; slv_err = 1'b0;
        observe(40);
        model_last = w;
        n_checks++; if (o_who !== w || o_lat !== 4 || o_err !== 1'b0) begin n_fail++; $display("FAIL rm_regrant1: got who=%0d lat=%0d err=%b expected who=%0d lat=4 err=0", o_who, o_lat, o_err, w); end
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
    endtask

    initial begin
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        apb_bus.Prdata = '0; apb_bus.Pready = 1'b0; apb_bus.Pslverr = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_contention();
        test_timeout();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
